// File: rtl/rv_pkg.sv
// Shared RV32I datapath constants and types used by the register file and
// the decoder-side address logic.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_word_t;

endpackage

// File: rtl/write_demux.sv
// Binary-to-one-hot steering decoder: routes a single enable to the one
// destination selected by sel.  Purely combinational.
module write_demux #(
    parameter int ADDR_W = 5
) (
    input  logic                  en,
    input  logic [ADDR_W-1:0]     sel,
    output logic [2**ADDR_W-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            // An unknown sel with en=0 still yields all zeros.
            onehot[i] = en & (sel == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/register_file_wdemux.sv
// RV32I integer register file: two combinational read ports, one clocked
// write port steered by a one-hot write demux.  x0 has no storage.
module register_file_wdemux #(
    parameter int XLEN         = rv_pkg::XLEN,
    parameter int REG_COUNT    = rv_pkg::REG_COUNT,
    parameter int ADDR_W       = rv_pkg::REG_ADDR_W,
    parameter int WRITE_BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
);

    import rv_pkg::*;

    logic [REG_COUNT-1:0] demux_onehot;
    logic [REG_COUNT-1:0] we_vec;

    logic [XLEN-1:0] regs_q [1:REG_COUNT-1];
    logic [XLEN-1:0] regs_d [1:REG_COUNT-1];

    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;
    logic            rs1_fwd;
    logic            rs2_fwd;

    write_demux #(
        .ADDR_W (ADDR_W)
    ) u_write_demux (
        .en     (reg_write),
        .sel    (rd_addr),
        .onehot (demux_onehot)
    );

    // x0 is hardwired: its enable is masked here, so neither storage nor the
    // bypass path can ever see a write to address 0.
    assign we_vec = demux_onehot & ~REG_COUNT'(1);

    always_comb begin
        for (int i = 1; i < REG_COUNT; i++) begin
            regs_d[i] = we_vec[i] ? wr_data : regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (rs1_addr == ADDR_W'(i)) rs1_stored = regs_q[i];
            if (rs2_addr == ADDR_W'(i)) rs2_stored = regs_q[i];
        end
    end

    // Forwarding is keyed off we_vec, so x0 is excluded by construction;
    // reset suppresses it so both read ports show zero while reset is high.
    assign rs1_fwd = (WRITE_BYPASS != 0) && !reset && we_vec[rs1_addr];
    assign rs2_fwd = (WRITE_BYPASS != 0) && !reset && we_vec[rs2_addr];

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != ADDR_W'(REG_ZERO)) begin
            rs1_data = rs1_fwd ? wr_data : rs1_stored;
        end
        if (rs2_addr != ADDR_W'(REG_ZERO)) begin
            rs2_data = rs2_fwd ? wr_data : rs2_stored;
        end
    end

endmodule

// File: tb/tb_register_file_wdemux.sv
// Bench for register_file_wdemux: one instance without and one with write
// bypass, driven by shared inputs and checked against an array model.
`timescale 1ns/10ps
module tb_register_file_wdemux;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] d0_rs1, d0_rs2, d1_rs1, d1_rs2;

    logic [31:0] obs [4];
    logic [31:0] model [32];
    int n_cmp;
    int n_bad;

    register_file_wdemux #(.WRITE_BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .rd_addr(rd_addr),
        .wr_data(wr_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d0_rs1), .rs2_data(d0_rs2)
    );

    register_file_wdemux #(.WRITE_BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .rd_addr(rd_addr),
        .wr_data(wr_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d1_rs1), .rs2_data(d1_rs2)
    );

    assign obs[0] = d0_rs1;
    assign obs[1] = d0_rs2;
    assign obs[2] = d1_rs1;
    assign obs[3] = d1_rs2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Architectural view of a read: x0 is zero, reset forces zero, a bypassing
    // instance sees the in-flight write, otherwise the last committed value.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (reset) return 32'h0;
        if (byp && reg_write && rd_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = a;
        wr_data   = d;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        #1;
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            do_write(5'($urandom_range(1, 31)), $urandom);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #0.05;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs[k] !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_read addr=%0d port=%0d got=%h exp=00000000",
                             (k % 2 == 0) ? rs1_addr : rs2_addr, k, obs[k]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        rs1_addr = 5'd5;
        rs2_addr = 5'd4;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs[k] !== ((k % 2 == 0) ? 32'hDEADBEEF : 32'h0)) begin
                n_bad++;
                $display("FAIL basic_x5_x4 port=%0d got=%h", k, obs[k]);
            end
        end
        rs1_addr = 5'd6;
        #1;
        n_cmp++;
        if (d0_rs1 !== 32'h0 || d1_rs1 !== 32'h0) begin
            n_bad++;
            $display("FAIL basic_x6 got=%h/%h exp=00000000", d0_rs1, d1_rs1);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd0;
        wr_data   = 32'hFFFFFFFF;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        for (int phase = 0; phase < 2; phase++) begin
            #1;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs[k] !== 32'h0) begin
                    n_bad++;
                    $display("FAIL x0_protect phase=%0d port=%0d got=%h exp=00000000",
                             phase, k, obs[k]);
                end
            end
            @(posedge clk);
        end
        #1;
        reg_write = 1'b0;
    endtask

    task automatic test_write_disable();
        do_write(5'd7, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reg_write = 1'b0;
            rd_addr   = 5'd7;
            wr_data   = 32'hAAAAAAAA;
            rs1_addr  = 5'd7;
            rs2_addr  = 5'd7;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs[k] !== 32'h12345678) begin
                    n_bad++;
                    $display("FAIL write_disable cycle=%0d port=%0d got=%h exp=12345678",
                             c, k, obs[k]);
                end
            end
        end
    endtask

    task automatic test_collision();
        do_write(5'd9, 32'h11111111);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd9;
        wr_data   = 32'h22222222;
        rs1_addr  = 5'd9;
        rs2_addr  = 5'd9;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs[k] !== ((k >= 2) ? 32'h22222222 : 32'h11111111)) begin
                n_bad++;
                $display("FAIL collision_before port=%0d got=%h", k, obs[k]);
            end
        end
        @(posedge clk);
        model[9] = 32'h22222222;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs[k] !== 32'h22222222) begin
                n_bad++;
                $display("FAIL collision_after port=%0d got=%h exp=22222222", k, obs[k]);
            end
        end
        reg_write = 1'b0;
    endtask

    task automatic test_walking();
        logic [31:0] exp;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h01010101);
        end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'((i + 1) % 32);
            #0.2;
            for (int k = 0; k < 4; k++) begin
                exp = (k % 2 == 0) ? 32'(i) * 32'h01010101
                                   : 32'((i + 1) % 32) * 32'h01010101;
                n_cmp++;
                if (obs[k] !== exp) begin
                    n_bad++;
                    $display("FAIL walking addr=%0d port=%0d got=%h exp=%h",
                             (k % 2 == 0) ? rs1_addr : rs2_addr, k, obs[k], exp);
                end
            end
        end
    endtask

    task automatic test_reset_during_write();
        do_write(5'd3, 32'h0BADF00D);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd3;
        wr_data   = 32'hCAFEF00D;
        rs1_addr  = 5'd3;
        rs2_addr  = 5'd3;
        reset     = 1'b1;
        clear_model();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_mid_write_during port=%0d got=%h exp=00000000", k, obs[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        reg_write = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_mid_write_after port=%0d got=%h exp=00000000", k, obs[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            reg_write = ($urandom_range(0, 3) != 0);
            rd_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            rs1_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr  = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            #2;
            for (int k = 0; k < 4; k++) begin
                exp = ref_read((k % 2 == 0) ? rs1_addr : rs2_addr, k >= 2);
                n_cmp++;
                if (obs[k] !== exp) begin
                    n_bad++;
                    $display("FAIL random cyc=%0d port=%0d addr=%0d got=%h exp=%h",
                             c, k, (k % 2 == 0) ? rs1_addr : rs2_addr, obs[k], exp);
                end
            end
            @(posedge clk);
            if (reg_write && rd_addr != 5'd0) model[rd_addr] = wr_data;
        end
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        reg_write = 1'b0;
        rd_addr   = 5'd0;
        wr_data   = 32'h0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_basic();
        test_x0();
        test_write_disable();
        test_collision();
        test_walking();
        test_reset_during_write();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
